// File: rtl/tinker_pkg.sv
// rtl/tinker_pkg.sv - shared constants, state encodings and types for the tinker fetch stage
package tinker_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 64;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 64'h2000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam int OPCODE_LSB = 27;
    localparam int OPCODE_W   = 5;
    localparam int RD_LSB     = 22;
    localparam int RS_LSB     = 17;
    localparam int RT_LSB     = 12;
    localparam int REG_W      = 5;
    localparam int L_LSB      = 0;
    localparam int L_W        = 12;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] word;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~64'd3;
    endfunction

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] w);
        return w[OPCODE_LSB +: OPCODE_W];
    endfunction

    function automatic logic [REG_W-1:0] rd_of(input logic [INSTR_W-1:0] w);
        return w[RD_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] rs_of(input logic [INSTR_W-1:0] w);
        return w[RS_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] rt_of(input logic [INSTR_W-1:0] w);
        return w[RT_LSB +: REG_W];
    endfunction

    function automatic logic [L_W-1:0] imm_of(input logic [INSTR_W-1:0] w);
        return w[L_LSB +: L_W];
    endfunction

endpackage

// File: rtl/tinker_fetch_fifo.sv
// rtl/tinker_fetch_fifo.sv - instruction buffer between imem responses and the decoder
module tinker_fetch_fifo
    import tinker_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Flush wins over both push and pop so a redirect never leaks a stale word.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/tinker_fetch.sv
// rtl/tinker_fetch.sv - fetch stage: pc sequencing, imem read issue, redirect/halt squash
module tinker_fetch
    import tinker_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_rd_en,
    output logic [63:0]         imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  instruction,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                redirect_valid,
    input  logic [63:0]         redirect_pc,
    input  logic                halt_req,
    output logic                halted,
    output logic [63:0]         instr_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]     state;
    logic [63:0]    pc;
    logic [63:0]    inflight_pc;
    logic           inflight;
    logic           fire;
    logic           flush;
    logic           issue;
    logic           push;
    logic [CW-1:0]  count;
    logic [CW:0]    load;
    logic           full;
    logic           empty;
    fetch_entry_t   head;
    fetch_entry_t   push_data;

    assign fire  = instr_valid && instr_ready;
    assign flush = ((state == ST_RUN) && halt_req) || (redirect_valid && (state != ST_IDLE));

    // The word leaving this cycle frees its slot, which keeps DEPTH=2 at full rate.
    assign load  = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, fire};
    assign issue = (state == ST_RUN) && !flush && (load < (CW+1)'(DEPTH));

    assign push      = inflight && !full;
    assign push_data = '{pc: inflight_pc, word: imem_rdata};

    assign imem_rd_en  = issue;
    assign imem_addr   = pc;
    assign instr_valid = !empty;
    assign instruction = empty ? '0 : head.word;
    assign instr_pc    = empty ? '0 : head.pc;
    assign halted      = (state == ST_HALTED);

    tinker_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (fire),
        .flush     (flush),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // A squashed read is simply never marked in flight, so its response is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            case (state)
                ST_IDLE: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state <= ST_HALTED;
                    end
                    if (redirect_valid) begin
                        pc <= word_align(redirect_pc);
                    end else if (issue) begin
                        pc <= pc + 64'd4;
                    end
                end
                ST_HALTED: begin
                    if (redirect_valid) begin
                        state <= ST_RUN;
                        pc    <= word_align(redirect_pc);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
